// File: rtl/inst_seq_pkg.sv
// Shared types and default sizing for the instruction sequencer.
// The optional loop feature is enabled by defining INST_SEQ_LOOP_EN.
package inst_seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int unsigned DEF_INST_WIDTH = 32;
   localparam int unsigned DEF_TAG_WIDTH  = 8;
   localparam int unsigned DEF_ADDR_BITS  = 5;
   localparam int unsigned DEF_CTRL_DELAY = 7;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port instruction store: one write port, one registered read port.
// Only the read data register is reset; the array contents survive rst.
module sdp_ram
   import inst_seq_pkg::*;
#(
   parameter int unsigned INST_WIDTH = DEF_INST_WIDTH,
   parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_BITS-1:0]  waddr,
   input  logic [INST_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_BITS-1:0]  raddr,
   output logic [INST_WIDTH-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_BITS;

   logic [INST_WIDTH-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // rdata doubles as the issued instruction, so it holds when re is low
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/inst_seq.sv
// Tagged instruction loader and sequencer: a falling edge on valid replays the
// loaded program. Define INST_SEQ_LOOP_EN to add loop_cnt (repeat passes per run).
module inst_seq
   import inst_seq_pkg::*;
#(
   parameter int unsigned INST_WIDTH = DEF_INST_WIDTH,
   parameter int unsigned TAG_WIDTH  = DEF_TAG_WIDTH,
   parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
   parameter int unsigned CTRL_DELAY = DEF_CTRL_DELAY
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            valid,
   input  logic [TAG_WIDTH-1:0]            tag,
   input  logic [TAG_WIDTH+INST_WIDTH-1:0] ins,
   input  logic                            clr,
`ifdef INST_SEQ_LOOP_EN
   input  logic [7:0]                      loop_cnt,
`endif
   output logic [INST_WIDTH-1:0]           inst,
   output logic                            inst_vld,
   output logic                            control_dly,
   output logic [ADDR_BITS:0]              count,
   output logic                            busy,
   output logic                            full,
   output logic                            dropped
);

   localparam int unsigned      DEPTH   = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(DEPTH);
   localparam logic [ADDR_BITS:0] CNT_ONE = (ADDR_BITS+1)'(1);
   localparam logic [ADDR_BITS-1:0] PC_ONE = ADDR_BITS'(1);

   state_t               state, state_n;
   logic [ADDR_BITS-1:0] pc, pc_n;
   logic                 pending, pending_n;
   logic                 valid_d1;
   logic                 fall;
   logic                 hit;
   logic                 wr_en;
   logic                 rd_en;
   logic                 last;
   logic                 loop_more;

`ifdef INST_SEQ_LOOP_EN
   logic [7:0] loop_rem, loop_rem_n;
   assign loop_more = (loop_rem != '0);
`else
   assign loop_more = 1'b0;
`endif

   assign fall  = valid_d1 & ~valid;
   assign hit   = (ins[TAG_WIDTH+INST_WIDTH-1 -: TAG_WIDTH] == tag) && (ins != '0);
   assign full  = (count == DEPTH_C);
   assign busy  = (state == RUN);
   assign wr_en = hit & ~full & (state == IDLE) & ~clr;
   assign rd_en = (state == RUN) & ~clr;
   assign last  = ({1'b0, pc} == (count - CNT_ONE));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= '0;
         pending  <= 1'b0;
         valid_d1 <= 1'b0;
         inst_vld <= 1'b0;
`ifdef INST_SEQ_LOOP_EN
         loop_rem <= '0;
`endif
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         pending  <= pending_n;
         valid_d1 <= valid;
         inst_vld <= rd_en;
`ifdef INST_SEQ_LOOP_EN
         loop_rem <= loop_rem_n;
`endif
      end
   end

   // An edge landing on the final cycle restarts directly, avoiding a gap cycle
   always_comb begin
      state_n   = state;
      pc_n      = pc;
      pending_n = pending;
`ifdef INST_SEQ_LOOP_EN
      loop_rem_n = loop_rem;
`endif
      case (state)
         IDLE: begin
            if (fall && ((count != '0) || wr_en)) begin
               state_n   = RUN;
               pc_n      = '0;
               pending_n = 1'b0;
`ifdef INST_SEQ_LOOP_EN
               loop_rem_n = loop_cnt;
`endif
            end
         end
         RUN: begin
            pc_n = pc + PC_ONE;
            if (last) begin
               if (loop_more) begin
                  pc_n      = '0;
                  pending_n = pending | fall;
`ifdef INST_SEQ_LOOP_EN
                  loop_rem_n = loop_rem - 8'd1;
`endif
               end else if (pending || fall) begin
                  pc_n      = '0;
                  pending_n = pending & fall;
`ifdef INST_SEQ_LOOP_EN
                  loop_rem_n = loop_cnt;
`endif
               end else begin
                  state_n   = IDLE;
                  pending_n = 1'b0;
               end
            end else begin
               pending_n = pending | fall;
            end
         end
         default: state_n = IDLE;
      endcase
      if (clr) begin
         state_n   = IDLE;
         pc_n      = '0;
         pending_n = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         dropped <= 1'b0;
      end else if (clr) begin
         count   <= '0;
         dropped <= 1'b0;
      end else begin
         if (wr_en) begin
            count <= count + CNT_ONE;
         end
         if (hit && (full || (state == RUN))) begin
            dropped <= 1'b1;
         end
      end
   end

   sdp_ram #(
      .INST_WIDTH (INST_WIDTH),
      .ADDR_BITS  (ADDR_BITS)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en),
      .waddr (count[ADDR_BITS-1:0]),
      .wdata (ins[INST_WIDTH-1:0]),
      .re    (rd_en),
      .raddr (pc),
      .rdata (inst)
   );

   generate
      if (CTRL_DELAY == 0) begin : g_no_dly
         assign control_dly = inst_vld;
      end else begin : g_dly
         logic [CTRL_DELAY-1:0] dly;
         always_ff @(posedge clk) begin
            if (rst) begin
               dly <= '0;
            end else begin
               dly[0] <= inst_vld;
               for (int unsigned i = 1; i < CTRL_DELAY; i++) begin
                  dly[i] <= dly[i-1];
               end
            end
         end
         assign control_dly = dly[CTRL_DELAY-1];
      end
   endgenerate

endmodule

// File: tb/tb_inst_seq.sv
// Directed self-checking bench for inst_seq (default parameters, tag 0x08).
// Loop checks are included only when INST_SEQ_LOOP_EN is defined.
module tb_inst_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [7:0]  tag;
   logic [39:0] ins;
   logic        clr;
   logic [31:0] inst;
   logic        inst_vld;
   logic        control_dly;
   logic [5:0]  count;
   logic        busy;
   logic        full;
   logic        dropped;
`ifdef INST_SEQ_LOOP_EN
   logic [7:0]  loop_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   inst_seq #(
      .INST_WIDTH (32),
      .TAG_WIDTH  (8),
      .ADDR_BITS  (5),
      .CTRL_DELAY (7)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .valid       (valid),
      .tag         (tag),
      .ins         (ins),
      .clr         (clr),
`ifdef INST_SEQ_LOOP_EN
      .loop_cnt    (loop_cnt),
`endif
      .inst        (inst),
      .inst_vld    (inst_vld),
      .control_dly (control_dly),
      .count       (count),
      .busy        (busy),
      .full        (full),
      .dropped     (dropped)
   );

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic load(input logic [31:0] d, input logic [7:0] t = 8'h08);
      ins = {t, d};
      tick();
      ins = '0;
   endtask

   // Returns in cycle T, where valid_d1=1 and valid=0
   task automatic trig();
      valid = 1'b1;
      tick();
      valid = 1'b0;
   endtask

   logic [31:0] w3 [0:2];

   initial begin
      rst = 1'b1; valid = 1'b0; tag = 8'h08; ins = '0; clr = 1'b0;
`ifdef INST_SEQ_LOOP_EN
      loop_cnt = 8'd0;
`endif
      w3[0] = 32'h11; w3[1] = 32'h22; w3[2] = 32'h33;
      tick(2);
      rst = 1'b0;
      chk("rst_count", count, 0);
      chk("rst_vld", inst_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_full", full, 0);
      chk("rst_dropped", dropped, 0);
      chk("rst_inst", inst, 0);
      chk("rst_cdly", control_dly, 0);

      // Tag mismatch and all-zero word are ignored
      load(32'h1234_5678, 8'h09);
      ins = '0; tick();
      chk("mismatch_count", count, 0);
      chk("mismatch_dropped", dropped, 0);

      // Three-word run
      load(32'h11); load(32'h22); load(32'h33);
      chk("load3_count", count, 3);
      chk("load3_full", full, 0);
      trig();
      chk("run3_T_busy", busy, 0);
      tick();
      chk("run3_T1_busy", busy, 1);
      chk("run3_T1_vld", inst_vld, 0);
      tick();
      chk("run3_T2_vld", inst_vld, 1);
      chk("run3_T2_inst", inst, 32'h11);
      tick();
      chk("run3_T3_inst", inst, 32'h22);
      tick();
      chk("run3_T4_vld", inst_vld, 1);
      chk("run3_T4_inst", inst, 32'h33);
      chk("run3_T4_busy", busy, 0);
      tick();
      chk("run3_T5_vld", inst_vld, 0);
      chk("run3_T5_hold", inst, 32'h33);
      tick(3);
      chk("cdly_T8", control_dly, 0);
      tick();
      chk("cdly_T9", control_dly, 1);
      tick();
      chk("cdly_T10", control_dly, 1);
      tick();
      chk("cdly_T11", control_dly, 1);
      tick();
      chk("cdly_T12", control_dly, 0);

      // Restart edge at T+3 plus a load hit during RUN
      trig();
      tick();
      ins = {8'h08, 32'h44};
      tick();
      ins = '0;
      chk("rerun_dropped", dropped, 1);
      chk("rerun_count", count, 3);
      for (int k = 2; k <= 7; k++) begin
         chk("rerun_vld", inst_vld, 1);
         chk("rerun_inst", inst, w3[(k-2)%3]);
         if (k == 4) chk("rerun_T4_busy", busy, 1);
         if (k == 7) chk("rerun_T7_busy", busy, 0);
         if (k == 2) valid = 1'b1;
         if (k == 3) valid = 1'b0;
         tick();
      end
      chk("rerun_T8_vld", inst_vld, 0);

      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr_count", count, 0);
      chk("clr_dropped", dropped, 0);

      // Edge with empty program is ignored
      trig();
      tick();
      chk("empty_busy", busy, 0);
      tick();
      chk("empty_vld", inst_vld, 0);

      // clr at T+3 during a four-word run
      load(32'hA1); load(32'hA2); load(32'hA3); load(32'hA4);
      trig();
      tick(2);
      chk("clrrun_T2_inst", inst, 32'hA1);
      tick();
      chk("clrrun_T3_vld", inst_vld, 1);
      chk("clrrun_T3_inst", inst, 32'hA2);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clrrun_T4_vld", inst_vld, 0);
      chk("clrrun_T4_inst", inst, 32'hA2);
      chk("clrrun_T4_count", count, 0);
      chk("clrrun_T4_busy", busy, 0);
      tick();
      chk("clrrun_T5_vld", inst_vld, 0);

      // Load hit and falling edge in the same cycle
      valid = 1'b1; tick();
      valid = 1'b0; ins = {8'h08, 32'hB1};
      tick();
      ins = '0;
      chk("same_count", count, 1);
      chk("same_busy", busy, 1);
      tick();
      chk("same_vld", inst_vld, 1);
      chk("same_inst", inst, 32'hB1);
      tick();
      chk("same_end_vld", inst_vld, 0);

      // Fill to 32, then a 33rd word
      clr = 1'b1; tick(); clr = 1'b0;
      for (int i = 0; i < 32; i++) load(32'hC000_0000 | 32'(i + 1));
      chk("fill_count", count, 32);
      chk("fill_full", full, 1);
      chk("fill_dropped", dropped, 0);
      load(32'h99);
      chk("over_count", count, 32);
      chk("over_dropped", dropped, 1);
      trig();
      tick(2);
      for (int k = 0; k < 32; k++) begin
         chk("fill_vld", inst_vld, 1);
         chk("fill_inst", inst, 32'hC000_0000 | 32'(k + 1));
         tick();
      end
      chk("fill_end_vld", inst_vld, 0);
      chk("fill_end_busy", busy, 0);

      // rst mid-run
      trig();
      tick(2);
      chk("rstrun_T2_vld", inst_vld, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstrun_vld", inst_vld, 0);
      chk("rstrun_busy", busy, 0);
      chk("rstrun_count", count, 0);
      chk("rstrun_inst", inst, 0);
      chk("rstrun_dropped", dropped, 0);

`ifdef INST_SEQ_LOOP_EN
      load(32'hA); load(32'hB);
      loop_cnt = 8'd2;
      trig();
      tick(2);
      for (int k = 0; k < 6; k++) begin
         chk("loop_vld", inst_vld, 1);
         chk("loop_inst", inst, (k % 2 == 0) ? 32'hA : 32'hB);
         tick();
      end
      chk("loop_end_vld", inst_vld, 0);
      chk("loop_end_busy", busy, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_seq.md
INST_SEQ -- requirements
Module: inst_seq

Interface
REQ-001 Parameter INST_WIDTH, 32, instruction word width stored and issued.
REQ-002 Parameter TAG_WIDTH, 8, width of the destination tag carried above each instruction.
REQ-003 Parameter ADDR_BITS, 5, instruction store depth is 2**ADDR_BITS.
REQ-004 Parameter CTRL_DELAY, 7, cycles from inst_vld to control_dly; 0 means no delay.
REQ-005 Port clk, in, 1: the block's one clock; all logic on its rising edge.
REQ-006 Port rst, in, 1: reset, synchronous and active-high.
REQ-007 Port valid, in, 1: upstream data-valid; a falling edge triggers a program run.
REQ-008 Port tag, in, TAG_WIDTH: this instance's tag.
REQ-009 Port ins, in, TAG_WIDTH+INST_WIDTH: tagged load word, tag in the top TAG_WIDTH bits.
REQ-010 Port clr, in, 1: clears the loaded program.
REQ-011 Port inst, out, INST_WIDTH: issued instruction.
REQ-012 Port inst_vld, out, 1: inst is meaningful this cycle.
REQ-013 Port control_dly, out, 1: inst_vld delayed by CTRL_DELAY cycles.
REQ-014 Port count, out, ADDR_BITS+1: number of instructions loaded.
REQ-015 Port busy, out, 1: a run is in progress.
REQ-016 Port full, out, 1: count equals 2**ADDR_BITS.
REQ-017 Port dropped, out, 1: sticky; a matching load word was discarded.

Function
REQ-018 A load hit is ins top field equal to tag and ins nonzero.
REQ-019 In IDLE, a load hit with full low writes ins low INST_WIDTH bits at address count, and count increments by one the next cycle.
REQ-020 A load hit with full high, or in RUN, is discarded, count is unchanged, and dropped is set.
REQ-021 Falling edge is valid_d1 high and valid low, with valid_d1 a registered copy of valid.
REQ-022 The FSM has two states: IDLE and RUN.
REQ-023 IDLE->RUN on a falling edge with count nonzero; pc is set to 0. A falling edge with count zero is ignored.
REQ-024 RUN: pc increments by one each cycle. After pc = count-1, the FSM returns to IDLE, unless a restart is pending.
REQ-025 A falling edge during RUN sets one pending flag; further edges do not add to it. At run end the FSM stays in RUN with pc=0 and clears pending, so there is no gap cycle.
REQ-026 Falling edge at cycle T: inst for pc=k appears with inst_vld high at cycle T+2+k. inst_vld is high for exactly count consecutive cycles per run.
REQ-027 inst holds its last value when inst_vld is low.
REQ-028 A load hit and a falling edge in the same IDLE cycle: the write is committed, and the run uses the incremented count.
REQ-029 clr in any state: count=0, pending=0, dropped=0, FSM to IDLE. inst_vld is low from the next cycle, and any in-flight read is suppressed.
REQ-030 clr has priority over a simultaneous load hit and over a simultaneous falling edge.
REQ-031 busy is high exactly while the FSM is in RUN.

Reset
REQ-032 rst clears count, pc, pending, dropped, inst_vld, valid_d1 and the control_dly shift chain; inst resets to 0 and the FSM to IDLE.
REQ-033 rst asserted mid-run aborts the run; inst_vld is low on the first cycle after rst.
REQ-034 RAM contents are not cleared by rst.

Configuration
REQ-035 Macro INST_SEQ_LOOP_EN defined: adds input loop_cnt (8 bits), sampled at RUN entry; each triggered run issues the program loop_cnt+1 times back-to-back with no gap, and busy stays high throughout.
REQ-036 Macro INST_SEQ_LOOP_EN undefined: no loop_cnt port, one pass per trigger.

Structure
REQ-037 Shared package inst_seq_pkg holds the FSM state typedef (IDLE, RUN) and the default width/depth constants.
REQ-038 Storage is one sub-module, sdp_ram: simple dual-port, one write port and one synchronous read port, parametrised by INST_WIDTH and ADDR_BITS.

Verification
REQ-039 Load 3 hits (0x08_00000011, 0x08_00000022, 0x08_00000033), tag=0x08, then drop valid -> inst 0x11, 0x22, 0x33 at T+2..T+4; count=3; control_dly high at T+9..T+11.
REQ-040 Load 32 hits, then a 33rd -> full=1, count=32, dropped=1; run issues 32 words and the 33rd is absent.
REQ-041 Second falling edge at T+3 during a 3-word run -> inst_vld high continuously T+2..T+7; busy then falls.
REQ-042 Tag mismatch 0x09_xxxxxxxx and an all-zero ins -> count unchanged, dropped=0.
REQ-043 clr at T+3 during a 4-word run -> inst_vld low from T+4, count=0, busy=0.
REQ-044 INST_SEQ_LOOP_EN with loop_cnt=2 and 2 words loaded -> 6 consecutive inst_vld cycles, pattern A B A B A B.
